// File: rtl/i2c_reg_target_if.sv
// I2C target pin bundle plus the register-write notification port.
//
// Handshake: wr_stb is a valid-only strobe with no ready; it is high for
// exactly one clk cycle and wr_idx/wr_dat are meaningful only in that cycle.
// The consumer must accept it unconditionally. state_dbg mirrors the FSM
// state encoding for observation.
interface i2c_reg_target_if #(
  parameter int NREGS = 8
);
  localparam int IW = $clog2(NREGS);

  logic          scl_i;
  logic          sda_i;
  logic          sda_o;
  logic          sda_t;
  logic          wr_stb;
  logic [IW-1:0] wr_idx;
  logic [7:0]    wr_dat;
  logic          busy;
  logic [3:0]    state_dbg;

  modport slave (
    input  scl_i, sda_i,
    output sda_o, sda_t, wr_stb, wr_idx, wr_dat, busy, state_dbg
  );

  modport master (
    output scl_i, sda_i,
    input  sda_o, sda_t, wr_stb, wr_idx, wr_dat, busy, state_dbg
  );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C register-file target: 7-bit address, an index byte after the address,
// then sequential register writes or reads with auto-increment. SCL/SDA are
// synchronised and glitch-filtered; SDA changes are held off until a fixed
// delay after the filtered SCL falling edge.
module i2c_reg_target #(
  parameter logic [6:0] MYADDR = 7'h3a,
  parameter int         NREGS  = 8,
  parameter int         US     = 100,
  parameter int         FILT   = 3
) (
  input logic              clk,
  input logic              aresetn,
  i2c_reg_target_if.slave  bus
);

  localparam int         IW      = $clog2(NREGS);
  localparam int         HOLD    = (US * 3 + 9) / 10;
  localparam logic [15:0] HOLD_C = 16'(HOLD);
  localparam logic [7:0] FILT_M1 = 8'(FILT - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, IDX, ACK_I, WDAT, ACK_W, RDAT, RACK, IGNORE
  } state_t;

  logic [1:0]    scl_sync, sda_sync;
  logic [7:0]    scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_fd, sda_fd;
  logic          scl_rise, scl_fall, start_c, stop_c;
  logic [7:0]    shin;

  state_t        state;
  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          rw, host_ack, drive_req, sda_t_q, busy_q;
  logic [15:0]   hold_cnt;
  logic [IW-1:0] idx;
  logic          wr_stb_q;
  logic [IW-1:0] wr_idx_q;
  logic [7:0]    wr_dat_q;
  logic [7:0]    regs [NREGS];

  // Two-flop synchronisers, then a level is accepted only after FILT
  // consecutive samples that differ from the current filtered level.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_fd   <= 1'b1;
      sda_fd   <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == FILT_M1) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 8'd1;
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == FILT_M1) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 8'd1;
      scl_fd <= scl_f;
      sda_fd <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_fd;
  assign scl_fall = ~scl_f & scl_fd;
  assign start_c  = scl_f & scl_fd & sda_fd & ~sda_f;
  assign stop_c   = scl_f & scl_fd & ~sda_fd & sda_f;
  assign shin     = {shreg[6:0], sda_f};

  // Protocol FSM: bits are shifted on SCL rise, phase changes happen on SCL
  // fall; drive_req is what SDA should become, applied after the hold delay.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      host_ack  <= 1'b1;
      drive_req <= 1'b0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      hold_cnt  <= '0;
      idx       <= '0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_dat_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_stb_q <= 1'b0;
      if (scl_fall) hold_cnt <= '0;
      else if (!scl_f && hold_cnt != HOLD_C) hold_cnt <= hold_cnt + 16'd1;

      if (start_c) begin
        state     <= ADDR;
        bitcnt    <= '0;
        busy_q    <= 1'b1;
        drive_req <= 1'b0;
        sda_t_q   <= 1'b1;
      end else if (stop_c) begin
        state     <= IDLE;
        bitcnt    <= '0;
        busy_q    <= 1'b0;
        drive_req <= 1'b0;
        sda_t_q   <= 1'b1;
      end else begin
        if (!scl_f && !scl_fall && hold_cnt == HOLD_C) sda_t_q <= ~drive_req;
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg  <= shin;
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              bitcnt <= '0;
              if (shreg[7:1] == MYADDR) begin
                state     <= ACK_A;
                rw        <= shreg[0];
                drive_req <= 1'b1;
              end else state <= IGNORE;
            end
          end
          ACK_A: begin
            if (scl_fall) begin
              bitcnt <= '0;
              if (rw) begin
                state     <= RDAT;
                shreg     <= regs[idx];
                drive_req <= ~regs[idx][7];
              end else begin
                state     <= IDX;
                drive_req <= 1'b0;
              end
            end
          end
          IDX: begin
            if (scl_rise) begin
              shreg  <= shin;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) idx <= shin[IW-1:0];
            end else if (scl_fall && bitcnt == 4'd8) begin
              state     <= ACK_I;
              drive_req <= 1'b1;
              bitcnt    <= '0;
            end
          end
          ACK_I, ACK_W: begin
            if (scl_fall) begin
              state     <= WDAT;
              drive_req <= 1'b0;
              bitcnt    <= '0;
            end
          end
          WDAT: begin
            if (scl_rise) begin
              shreg  <= shin;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                regs[idx] <= shin;
                wr_stb_q  <= 1'b1;
                wr_idx_q  <= idx;
                wr_dat_q  <= shin;
                idx       <= idx + IW'(1);
              end
            end else if (scl_fall && bitcnt == 4'd8) begin
              state     <= ACK_W;
              drive_req <= 1'b1;
              bitcnt    <= '0;
            end
          end
          RDAT: begin
            if (scl_rise) bitcnt <= bitcnt + 4'd1;
            else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                state     <= RACK;
                idx       <= idx + IW'(1);
                drive_req <= 1'b0;
                bitcnt    <= '0;
              end else begin
                shreg     <= {shreg[6:0], 1'b0};
                drive_req <= ~shreg[6];
              end
            end
          end
          RACK: begin
            if (scl_rise) host_ack <= sda_f;
            else if (scl_fall) begin
              if (!host_ack) begin
                state     <= RDAT;
                shreg     <= regs[idx];
                drive_req <= ~regs[idx][7];
                bitcnt    <= '0;
              end else state <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_o     = 1'b0;
  assign bus.sda_t     = sda_t_q;
  assign bus.busy      = busy_q;
  assign bus.wr_stb    = wr_stb_q;
  assign bus.wr_idx    = wr_idx_q;
  assign bus.wr_dat    = wr_dat_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-level I2C host, register-file reference
// model, write scoreboard and SDA hold-timing monitor.
module tb_i2c_reg_target;
  localparam int         NREGS    = 8;
  localparam int         IW       = $clog2(NREGS);
  localparam logic [6:0] MYADDR   = 7'h3a;
  localparam int         TLOW     = 60;
  localparam int         THIGH    = 40;
  localparam int         HOLD_MIN = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aresetn = 1'b0;
  logic scl_h = 1'b1;
  logic sda_h = 1'b1;

  i2c_reg_target_if #(.NREGS(NREGS)) bus ();
  assign bus.scl_i = scl_h;
  assign bus.sda_i = sda_h & (bus.sda_t | bus.sda_o);

  i2c_reg_target #(.MYADDR(MYADDR), .NREGS(NREGS), .US(100), .FILT(3)) dut (
    .clk(clk), .aresetn(aresetn), .bus(bus)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]      m_regs [NREGS];
  int              m_idx;
  logic [IW+7:0]   exp_q[$];
  logic [IW+7:0]   obs_q[$];
  int              n_done = 0;

  int   trans_cnt = 0, bad_cnt = 0, low_drive_cnt = 0, low_cnt = 0;
  logic prev_t = 1'b1, rst_q = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_stb) obs_q.push_back({bus.wr_idx, bus.wr_dat});
    if (aresetn && rst_q && bus.sda_t !== prev_t) begin
      trans_cnt++;
      if (bus.scl_i || low_cnt < HOLD_MIN) bad_cnt++;
    end
    if (!bus.sda_t) low_drive_cnt++;
    low_cnt = bus.scl_i ? 0 : low_cnt + 1;
    prev_t  = bus.sda_t;
    rst_q   = aresetn;
  end

  task automatic check_writes();
    check("wr_count", obs_q.size(), exp_q.size());
    for (int i = n_done; i < exp_q.size() && i < obs_q.size(); i++)
      check("wr_entry", obs_q[i], exp_q[i]);
    n_done = exp_q.size();
  endtask

  // ---------------- host driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period starting just after SCL fell.
  task automatic bit_xfer(input logic b, input bit glitch, output logic r);
    wait_clk(10);
    sda_h = b;
    wait_clk(35);
    if (glitch) begin
      scl_h = 1'b1;
      wait_clk(1);
      scl_h = 1'b0;
      wait_clk(14);
    end else wait_clk(15);
    scl_h = 1'b1;
    wait_clk(THIGH / 2);
    r = bus.sda_i;
    wait_clk(THIGH / 2);
    scl_h = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_h) begin
      wait_clk(10);
      sda_h = 1'b1;
      wait_clk(TLOW - 10);
      scl_h = 1'b1;
      wait_clk(THIGH / 2);
    end
    sda_h = 1'b0;
    wait_clk(THIGH / 2);
    scl_h = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(10);
    sda_h = 1'b0;
    wait_clk(TLOW - 10);
    scl_h = 1'b1;
    wait_clk(THIGH / 2);
    sda_h = 1'b1;
    wait_clk(THIGH);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch, r);
    bit_xfer(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, r);
      b[i] = r;
    end
    bit_xfer(nack, 1'b0, r);
  endtask

  // Addressed write: index byte then n data bytes; no STOP.
  task automatic wr_txn(input logic [7:0] idx_b, input logic [7:0] d [8], input int n,
                        input bit glitch);
    logic ack;
    i2c_start();
    write_byte({MYADDR, 1'b0}, 1'b0, ack);
    check("wr_addr_ack", ack, 1'b0);
    write_byte(idx_b, 1'b0, ack);
    check("idx_ack", ack, 1'b0);
    m_idx = idx_b % NREGS;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({IW'(m_idx), d[k]});
      m_regs[m_idx] = d[k];
      m_idx = (m_idx + 1) % NREGS;
      write_byte(d[k], glitch, ack);
      check("wdat_ack", ack, 1'b0);
    end
  endtask

  // Addressed read of n bytes, ACKing all but the last; no STOP.
  task automatic rd_txn(input int n, input string tag, output logic [7:0] last);
    logic ack;
    logic [7:0] b;
    i2c_start();
    write_byte({MYADDR, 1'b1}, 1'b0, ack);
    check("rd_addr_ack", ack, 1'b0);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b);
      check(tag, b, m_regs[m_idx]);
      m_idx = (m_idx + 1) % NREGS;
    end
    last = b;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] d [8];
    logic [7:0] last;
    logic       ack, r;
    int         snap, n;

    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_idx = 0;

    // reset state
    wait_clk(3);
    check("rst_sda_t", bus.sda_t, 1'b1);
    check("rst_sda_o", bus.sda_o, 1'b0);
    check("rst_wr_stb", bus.wr_stb, 1'b0);
    check("rst_wr_idx", bus.wr_idx, 0);
    check("rst_wr_dat", bus.wr_dat, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state", bus.state_dbg, 4'd0);
    wait_clk(2);
    aresetn = 1'b1;
    wait_clk(10);

    // eight sequential writes from index 0, pointer wraps to 0
    for (int i = 0; i < 8; i++) d[i] = 8'((i + 1) * 17);
    wr_txn(8'h00, d, 8, 1'b0);
    check("busy_in_txn", bus.busy, 1'b1);
    i2c_stop();
    check("busy_after_stop", bus.busy, 1'b0);
    check_writes();
    rd_txn(1, "rd_wrap", last);
    check("rd_wrap_const", last, 8'h11);
    i2c_stop();

    // set index 0, repeated START, read nine bytes (ninth wraps)
    wr_txn(8'h00, d, 0, 1'b0);
    rd_txn(9, "rd_seq", last);
    check("rd_seq_ninth", last, 8'h11);
    i2c_stop();

    // foreign address: NACK, never driven, no writes, busy until STOP
    snap = low_drive_cnt;
    i2c_start();
    write_byte({7'h3b, 1'b0}, 1'b0, ack);
    check("foreign_ack", ack, 1'b1);
    write_byte(8'h55, 1'b0, ack);
    check("foreign_dat_ack", ack, 1'b1);
    check("foreign_busy", bus.busy, 1'b1);
    i2c_stop();
    check("foreign_busy_stop", bus.busy, 1'b0);
    check("foreign_no_drive", low_drive_cnt - snap, 0);
    check_writes();

    // read NACKed on first byte, STOP, pointer advanced by one
    rd_txn(1, "rd_nack", last);
    check("rd_nack_const", last, 8'h22);
    i2c_stop();
    check("nack_sda_t", bus.sda_t, 1'b1);
    check("nack_state", bus.state_dbg, 4'd0);
    rd_txn(1, "rd_after_nack", last);
    check("rd_after_nack_const", last, 8'h33);
    i2c_stop();

    // single-cycle SCL glitches inside every data bit are ignored
    d[0] = 8'($urandom_range(0, 255));
    d[1] = 8'($urandom_range(0, 255));
    wr_txn(8'($urandom_range(0, 255)), d, 2, 1'b1);
    i2c_stop();
    check_writes();

    // reset asserted while the address ACK is driven
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((MYADDR << 1) >> i) & 1, 1'b0, r);
    wait_clk(TLOW);
    scl_h = 1'b1;
    wait_clk(10);
    check("ack_driven", bus.sda_t, 1'b0);
    @(posedge clk);
    #3 aresetn = 1'b0;
    #1 check("rst_release", bus.sda_t, 1'b1);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_state", bus.state_dbg, 4'd0);
    wait_clk(5);
    aresetn = 1'b1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_idx = 0;
    wait_clk(5);
    scl_h = 1'b0;
    i2c_stop();
    rd_txn(2, "rd_after_rst", last);
    check("rd_after_rst_const", last, 8'h00);
    i2c_stop();

    // randomized write / read-back traffic
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 2);
      for (int k = 0; k < 8; k++) d[k] = 8'($urandom_range(0, 255));
      wr_txn(8'($urandom_range(0, 255)), d, n, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        m_idx = (m_idx + NREGS - n) % NREGS;
        wr_txn(8'(m_idx), d, 0, 1'b0);
      end
      rd_txn($urandom_range(1, 2), "rd_rand", last);
      i2c_stop();
      check_writes();
    end

    check("timing_viol", bad_cnt, 0);
    check("timing_seen", trans_cnt > 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 Parameter MYADDR, default 7'h3a: 7-bit I2C target address.
REQ-002 Parameter NREGS, default 8: number of 8-bit registers; power of 2, range 2..256.
REQ-003 Parameter US, default 100: clk cycles per microsecond; sets the SDA hold delay.
REQ-004 Parameter FILT, default 3: consecutive equal samples needed to accept a new SCL/SDA level.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 scl_i  in  1  bus SCL level; asynchronous to clk.
REQ-008 sda_i  in  1  bus SDA level; asynchronous to clk.
REQ-009 sda_o  out  1  SDA output value; constant 0.
REQ-010 sda_t  out  1  SDA tristate control; 1 = released (high-Z), 0 = drive sda_o (low).
REQ-011 wr_stb  out  1  one-cycle pulse when a bus write updates a register.
REQ-012 wr_idx  out  $clog2(NREGS)  index of the register written; valid with wr_stb.
REQ-013 wr_dat  out  8  value written; valid with wr_stb.
REQ-014 busy  out  1  1 from START to STOP, whether or not this target is addressed.

Function
REQ-015 SCL and SDA SHALL each pass a 2-FF synchronizer and then a FILT-sample glitch filter; all protocol decisions SHALL use the filtered levels.
REQ-016 START SHALL be filtered SDA 1->0 while filtered SCL=1; STOP SHALL be filtered SDA 0->1 while filtered SCL=1.
REQ-017 Data bits SHALL be sampled on the filtered SCL rising edge, MSB first.
REQ-018 FSM states SHALL be IDLE, ADDR, ACK_A, IDX, ACK_I, WDAT, ACK_W, RDAT, RACK, IGNORE.
REQ-019 START in any state SHALL go to ADDR, clear the bit counter and set busy; STOP in any state SHALL go to IDLE, release SDA and clear busy.
REQ-020 ADDR: after 8 bits, if bits[7:1]==MYADDR go to ACK_A; otherwise go to IGNORE and never drive SDA.
REQ-021 ACK_A: drive SDA low for the 9th clock; then go to IDX if R/W=0, or to RDAT if R/W=1 with the shift register loaded from regs[idx].
REQ-022 IDX: the 8 received bits SHALL be taken modulo NREGS into the index pointer idx; ACK in ACK_I; then go to WDAT.
REQ-023 WDAT: after 8 bits, write regs[idx], pulse wr_stb with wr_idx=idx and wr_dat=byte, increment idx modulo NREGS, ACK in ACK_W, then return to WDAT.
REQ-024 RDAT: drive SDA low when the current bit is 0 and release it when the bit is 1; after 8 bits increment idx modulo NREGS, release SDA, go to RACK.
REQ-025 RACK: sample the host's ACK on SCL rise; ACK (0) reloads the shift register from regs[idx] and returns to RDAT; NACK (1) goes to IGNORE.
REQ-026 sda_t changes SHALL occur only while filtered SCL=0, no earlier than ceil(US*0.3) clk cycles after the filtered SCL falling edge.
REQ-027 ACK/data drive SHALL be released at the falling edge that ends the bit (same hold delay).
REQ-028 idx SHALL persist across repeated START and STOP; only reset and an IDX byte change it.
REQ-029 Wrap-around: idx = NREGS-1 followed by an access SHALL make idx = 0.
REQ-030 No clock stretching; SCL is never driven.
REQ-031 START or STOP during an ACK or while driving data SHALL release SDA before the next clk edge.
REQ-032 A write byte that is interrupted by START or STOP before bit 8 SHALL be discarded: no register update and no wr_stb.

Reset
REQ-033 While aresetn=0: state IDLE, sda_t=1, sda_o=0, wr_stb=0, wr_idx=0, wr_dat=0, busy=0, idx=0, all regs=8'h00, synchronizers and filters=1.
REQ-034 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after reset the block waits for a fresh START.

Verification
REQ-035 Write {3a,W}, 00, 11, 22 … 88 (8 data bytes) -> all bytes ACKed, 8 wr_stb pulses with idx 0..7, idx wraps to 0.
REQ-036 Write {3a,W}, 00, then repeated START, {3a,R}, read 8 bytes ACKing all -> 11..88 returned; the 9th read returns 11 (wrap).
REQ-037 Address {3b,W} -> NACK (SDA never driven low), no wr_stb, busy=1 until STOP.
REQ-038 Read with NACK on the 1st byte, then STOP -> SDA released, state IDLE, idx advanced by 1.
REQ-039 1-cycle glitch on SCL with FILT=3 -> no bit sampled; assert aresetn=0 during an ACK -> sda_t=1 the same cycle, regs=00.
REQ-040 Timing check: every sda_t transition occurs with scl_i=0 and at least 30 clk cycles after the SCL fall (US=100).
